// File: rtl/core_pkg.sv
// Shared definitions for the fetch front end: FSM encoding, default reset PC, PC-to-word helper.
// Pure declarations; no latency or backpressure of its own.
// Imported by syn_pc_fetch.
package core_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Byte PC to 32-bit word index; callers slice to their memory width.
    function automatic logic [29:0] pc_to_word(input logic [31:0] pc_byte);
        return pc_byte[31:2];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter cleared by synchronous active-low reset.
// Latency: q updates the edge after en. Backpressure: none; holds at all-ones once full.
// Used for the optional branch statistics.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/syn_pc_fetch.sv
// PC register and fetch sequencer: fetches word at pc over req/ack, hands it to decode over valid/ready.
// Latency: one bubble after reset, then >=1 cycle fetch + >=1 cycle hold (2 cycles/instr best case).
// Backpressure: imem stall keeps req/addr stable; decode stall holds inst. Macro PC_BRANCH_STAT_EN adds counters.
module syn_pc_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               halt_req,
    input  logic [31:0]        pc_new,
    input  logic               branched,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_data,
    output logic [31:0]        inst,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        pc,
    output logic [31:0]        pc_4,
    output logic               halted,
    output logic [31:0]        taken_cnt,
    output logic [31:0]        retire_cnt
);

    fetch_state_t state;
    logic [29:0]  word_addr;
    logic         retire;

    assign word_addr = pc_to_word(pc);
    assign imem_addr = word_addr[IMEM_AW-1:0];
    assign pc_4      = pc + 32'd4;
    assign retire    = (state == S_HOLD) && inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        inst       <= imem_data;
                        inst_valid <= 1'b1;
                        imem_req   <= 1'b0;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (retire) begin
                        // Targets are word aligned; stray low bits from the where-to-go stage are dropped.
                        pc         <= {pc_new[31:2], 2'b00};
                        inst_valid <= 1'b0;
                        if (halt_req) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    halted     <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PC_BRANCH_STAT_EN
    sat_counter #(.W(32)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire),
        .q     (retire_cnt)
    );

    sat_counter #(.W(32)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire && branched),
        .q     (taken_cnt)
    );

    logic unused_bits;
    assign unused_bits = ^{pc_new[1:0], word_addr};
`else
    assign retire_cnt = 32'd0;
    assign taken_cnt  = 32'd0;

    logic unused_bits;
    assign unused_bits = ^{pc_new[1:0], word_addr, branched, retire};
`endif

endmodule

// File: tb/tb_syn_pc_fetch.sv
// Directed table-driven bench for syn_pc_fetch plus hand sequences for reset-during-ack and PC wrap.
module tb_syn_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt_req;
    logic [31:0] pc_new;
    logic        branched;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        halted;
    logic [31:0] taken_cnt;
    logic [31:0] retire_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    syn_pc_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .halt_req   (halt_req),
        .pc_new     (pc_new),
        .branched   (branched),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc         (pc),
        .pc_4       (pc_4),
        .halted     (halted),
        .taken_cnt  (taken_cnt),
        .retire_cnt (retire_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic [31:0] data;
        logic        ready;
        logic [31:0] pc_new;
        logic        br;
        logic        halt;
        logic        e_req;
        logic [9:0]  e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_halted;
        logic [31:0] e_taken;
        logic [31:0] e_retire;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    task automatic add(input logic r, input logic a, input logic [31:0] d, input logic rd,
                       input logic [31:0] pn, input logic b, input logic h,
                       input logic e_req, input logic [9:0] e_addr, input logic e_valid,
                       input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_halted,
                       input logic [31:0] e_taken, input logic [31:0] e_retire);
        vecs[nvec] = '{r, a, d, rd, pn, b, h, e_req, e_addr, e_valid, e_inst, e_pc, e_halted,
                       e_taken, e_retire};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Counter expectations collapse to zero when statistics are compiled out.
    function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef PC_BRANCH_STAT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic a, input logic [31:0] d, input logic rd,
                         input logic [31:0] pn, input logic b, input logic h);
        rst_n = r; imem_ack = a; imem_data = d; inst_ready = rd;
        pc_new = pn; branched = b; halt_req = h;
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset (ack during reset dropped), then sequential fetch 0,4,8.
        add(0,1,32'h1111_1111,0,32'h0,0,0,  0,10'd0,0,32'h0,32'h0,0, 0,0);
        add(0,0,32'h0,0,32'h0,0,0,          0,10'd0,0,32'h0,32'h0,0, 0,0);
        add(1,0,32'h0,0,32'h0,0,0,          1,10'd0,0,32'h0,32'h0,0, 0,0);
        add(1,1,32'hA000_0000,0,32'h0,0,0,  0,10'd0,1,32'hA000_0000,32'h0,0, 0,0);
        add(1,0,32'h0,1,32'h4,0,0,          1,10'd1,0,32'h0,32'h4,0, 0,1);
        add(1,1,32'hA000_0001,0,32'h0,0,0,  0,10'd1,1,32'hA000_0001,32'h4,0, 0,1);
        add(1,0,32'h0,1,32'h8,0,0,          1,10'd2,0,32'h0,32'h8,0, 0,2);
        add(1,1,32'hA000_0002,0,32'h0,0,0,  0,10'd2,1,32'hA000_0002,32'h8,0, 0,2);
        // Taken branch to 0x40.
        add(1,0,32'h0,1,32'h40,1,0,         1,10'd16,0,32'h0,32'h40,0, 1,3);
        // Fetch stalls 5 cycles, then decode stalls 3 cycles (stray ack ignored).
        for (int i = 0; i < 5; i++)
            add(1,0,32'h0,0,32'h0,0,0,      1,10'd16,0,32'h0,32'h40,0, 1,3);
        add(1,1,32'hB000_0003,0,32'h0,0,0,  0,10'd16,1,32'hB000_0003,32'h40,0, 1,3);
        for (int i = 0; i < 3; i++)
            add(1,1,32'hDEAD_BEEF,0,32'h100,1,1, 0,10'd16,1,32'hB000_0003,32'h40,0, 1,3);
        add(1,0,32'h0,1,32'h44,0,0,         1,10'd17,0,32'h0,32'h44,0, 1,4);
        // Halt request while fetching has no effect; halt at retirement is sticky.
        add(1,0,32'h0,0,32'h0,0,1,          1,10'd17,0,32'h0,32'h44,0, 1,4);
        add(1,1,32'hC000_0000,0,32'h0,0,0,  0,10'd17,1,32'hC000_0000,32'h44,0, 1,4);
        add(1,0,32'h0,1,32'h80,0,1,         0,10'd32,0,32'h0,32'h80,1, 1,5);
        for (int i = 0; i < 3; i++)
            add(1,1,32'h5555_5555,1,32'h200,1,0, 0,10'd32,0,32'h0,32'h80,1, 1,5);

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].rst_n, vecs[i].ack, vecs[i].data, vecs[i].ready,
                  vecs[i].pc_new, vecs[i].br, vecs[i].halt);
            step();
            chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d pc_4", i), pc_4, vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
            if (vecs[i].e_req)
                chk($sformatf("v%0d imem_addr", i), {22'd0, imem_addr}, {22'd0, vecs[i].e_addr});
            if (vecs[i].e_valid || !vecs[i].rst_n)
                chk($sformatf("v%0d inst", i), inst, vecs[i].e_inst);
            chk($sformatf("v%0d taken_cnt", i), taken_cnt, stat(vecs[i].e_taken));
            chk($sformatf("v%0d retire_cnt", i), retire_cnt, stat(vecs[i].e_retire));
        end

        // Reset asserted mid-fetch together with ack: reset wins.
        drive(0, 0, 32'h0, 0, 32'h0, 0, 0); step();
        drive(1, 0, 32'h0, 0, 32'h0, 0, 0); step();
        step();
        chk("pre_rst imem_req", {31'd0, imem_req}, 32'd1);
        drive(0, 1, 32'hDEAD_0001, 0, 32'h0, 0, 0); step();
        chk("rst_ack pc", pc, 32'h0);
        chk("rst_ack inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_ack imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_ack inst", inst, 32'h0);
        chk("rst_ack halted", {31'd0, halted}, 32'd0);
        drive(1, 0, 32'h0, 0, 32'h0, 0, 0); step();
        chk("rel imem_req", {31'd0, imem_req}, 32'd1);

        // PC wrap and low-bit masking.
        drive(1, 1, 32'h0000_0001, 0, 32'h0, 0, 0); step();
        drive(1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0); step();
        chk("wrap pc", pc, 32'hFFFF_FFFC);
        chk("wrap pc_4", pc_4, 32'h0);
        chk("wrap imem_addr", {22'd0, imem_addr}, 32'h3FF);
        drive(1, 1, 32'h0000_0002, 0, 32'h0, 0, 0); step();
        drive(1, 0, 32'h0, 1, 32'h0, 0, 0); step();
        chk("wrapped pc", pc, 32'h0);
        drive(1, 1, 32'h0000_0003, 0, 32'h0, 0, 0); step();
        drive(1, 0, 32'h0, 1, 32'h0000_0013, 0, 0); step();
        chk("mask pc", pc, 32'h0000_0010);
        chk("mask imem_addr", {22'd0, imem_addr}, 32'd4);
        chk("post_rst retire_cnt", retire_cnt, stat(32'd3));
        chk("post_rst taken_cnt", taken_cnt, stat(32'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
